// File: rtl/ahb_button_pkg.sv
// Shared register map for the AHB button/IRQ peripheral.
// Offsets are word indices, decoded from HADDR[4:2].
package ahb_button_pkg;

  localparam int unsigned ADDR_DEC_W = 3;

  localparam logic [ADDR_DEC_W-1:0] REG_DATA    = 3'd0;
  localparam logic [ADDR_DEC_W-1:0] REG_RAW     = 3'd1;
  localparam logic [ADDR_DEC_W-1:0] REG_RISE_EN = 3'd2;
  localparam logic [ADDR_DEC_W-1:0] REG_FALL_EN = 3'd3;
  localparam logic [ADDR_DEC_W-1:0] REG_STATUS  = 3'd4;

endpackage

// File: rtl/ahb_button_irq_debounce.sv
// One button channel: 2-FF synchroniser, hold-time debouncer and edge detector.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic button,
  output logic sync,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int unsigned      CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      meta     <= button;
      sync     <= meta;
      stable_d <= stable;
      // Any return to the stable level restarts the hold count.
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

endmodule

// File: rtl/ahb_button_irq.sv
// AHB-Lite zero-wait-state slave: debounced buttons with per-edge interrupt
// enables, sticky W1C status and one level IRQ.
module ahb_button_irq
  import ahb_button_pkg::*;
#(
  parameter int unsigned N_BTN           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic             HREADY,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  input  logic [N_BTN-1:0] BUTTON,
  output logic             IRQ
);

  logic                  r_hsel;
  logic                  r_hwrite;
  logic [1:0]            r_htrans;
  logic [ADDR_DEC_W-1:0] r_haddr;

  logic [N_BTN-1:0] sync_vec;
  logic [N_BTN-1:0] stable_vec;
  logic [N_BTN-1:0] rise_vec;
  logic [N_BTN-1:0] fall_vec;

  logic [N_BTN-1:0] rise_en;
  logic [N_BTN-1:0] fall_en;
  logic [N_BTN-1:0] status;
  logic [N_BTN-1:0] w1c;
  logic [N_BTN-1:0] wdata;

  logic wr_act;
  logic rd_act;
  logic unused_ok;

  assign HREADYOUT = 1'b1;
  assign unused_ok = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA};

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .HCLK   (HCLK),
      .HRESETn(HRESETn),
      .button (BUTTON[i]),
      .sync   (sync_vec[i]),
      .stable (stable_vec[i]),
      .rise   (rise_vec[i]),
      .fall   (fall_vec[i])
    );
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hsel   <= 1'b0;
      r_hwrite <= 1'b0;
      r_htrans <= '0;
      r_haddr  <= '0;
    end else if (HREADY) begin
      r_hsel   <= HSEL;
      r_hwrite <= HWRITE;
      r_htrans <= HTRANS;
      r_haddr  <= HADDR[4:2];
    end
  end

  assign wr_act = r_hsel & r_htrans[1] & r_hwrite & HREADY;
  assign rd_act = r_hsel & r_htrans[1] & ~r_hwrite;
  assign wdata  = HWDATA[N_BTN-1:0];
  assign w1c    = (wr_act && (r_haddr == REG_STATUS)) ? wdata : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rise_en <= '0;
      fall_en <= '0;
    end else if (wr_act) begin
      if (r_haddr == REG_RISE_EN) rise_en <= wdata;
      if (r_haddr == REG_FALL_EN) fall_en <= wdata;
    end
  end

  // Set terms are OR-ed after the clear so a same-cycle edge is never lost.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      status <= '0;
      IRQ    <= 1'b0;
    end else begin
      status <= (status & ~w1c) | (rise_vec & rise_en) | (fall_vec & fall_en);
      IRQ    <= |status;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_act) begin
      case (r_haddr)
        REG_DATA:    HRDATA = 32'(stable_vec);
        REG_RAW:     HRDATA = 32'(sync_vec);
        REG_RISE_EN: HRDATA = 32'(rise_en);
        REG_FALL_EN: HRDATA = 32'(fall_en);
        REG_STATUS:  HRDATA = 32'(status);
        default:     HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_button_irq.sv
// Directed bench for ahb_button_irq (N_BTN=8, DEBOUNCE_CYCLES=4); read
// expectations go through a scoreboard queue and are checked in the data phase.
module tb_ahb_button_irq;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic [7:0]  BUTTON;
  logic        IRQ;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [31:0] A_DATA    = 32'h00;
  localparam logic [31:0] A_RAW     = 32'h04;
  localparam logic [31:0] A_RISE_EN = 32'h08;
  localparam logic [31:0] A_FALL_EN = 32'h0C;
  localparam logic [31:0] A_STATUS  = 32'h10;

  ahb_button_irq #(
    .N_BTN          (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSEL     (HSEL),
    .HREADY   (HREADY),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HREADYOUT(HREADYOUT),
    .HRDATA   (HRDATA),
    .BUTTON   (BUTTON),
    .IRQ      (IRQ)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: address phase now, data phase checked at next negedge.
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = addr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge HCLK);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    check(tag_q.pop_front(), HRDATA, exp_q.pop_front());
  endtask

  // Called at a negedge; returns with the data phase in progress.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = addr;
    @(negedge HCLK);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HWDATA = data;
  endtask

  initial begin
    HRESETn = 1'b0;
    HSEL    = 1'b0;
    HREADY  = 1'b1;
    HADDR   = '0;
    HTRANS  = 2'b00;
    HWRITE  = 1'b0;
    HSIZE   = 3'b010;
    HWDATA  = '0;
    BUTTON  = '0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Reset state
    check("hreadyout", 32'(HREADYOUT), 32'd1);
    check("irq_reset", 32'(IRQ), 32'd0);
    for (int i = 0; i < 8; i++) rd(32'(i * 4), 32'h0, $sformatf("reset_rd_%0d", i));

    // Synchroniser and debounce latency
    BUTTON = 8'h01;
    rd(A_RAW,  32'h00, "raw_1cyc");
    rd(A_RAW,  32'h01, "raw_2cyc");
    rd(A_DATA, 32'h00, "data_3cyc");
    rd(A_DATA, 32'h00, "data_4cyc");
    rd(A_DATA, 32'h00, "data_5cyc");
    rd(A_DATA, 32'h01, "data_6cyc");
    rd(A_STATUS, 32'h00, "status_no_en");
    check("irq_no_en", 32'(IRQ), 32'd0);

    // Short glitch is rejected
    BUTTON = 8'h09;
    repeat (3) @(negedge HCLK);
    BUTTON = 8'h01;
    repeat (8) @(negedge HCLK);
    rd(A_DATA,   32'h01, "glitch_data");
    rd(A_STATUS, 32'h00, "glitch_status");

    // Rising-edge interrupt, back-to-back write/read, W1C clear
    wr(A_RISE_EN, 32'h04);
    rd(A_RISE_EN, 32'h04, "rise_en_b2b");
    BUTTON = 8'h05;
    repeat (5) @(negedge HCLK);
    rd(A_STATUS, 32'h00, "rise_status_early");
    rd(A_STATUS, 32'h04, "rise_status_set");
    check("irq_lag", 32'(IRQ), 32'd0);
    @(negedge HCLK);
    check("irq_set", 32'(IRQ), 32'd1);
    wr(A_STATUS, 32'h04);
    rd(A_STATUS, 32'h00, "w1c_clear");
    check("irq_clear_lag", 32'(IRQ), 32'd1);
    @(negedge HCLK);
    check("irq_cleared", 32'(IRQ), 32'd0);

    // Falling edge coincident with W1C: set wins
    BUTTON = 8'h85;
    repeat (10) @(negedge HCLK);
    rd(A_DATA,   32'h85, "data_b7_high");
    rd(A_STATUS, 32'h00, "status_b7_rise_masked");
    wr(A_FALL_EN, 32'h80);
    rd(A_FALL_EN, 32'h80, "fall_en_rd");
    BUTTON = 8'h05;
    repeat (5) @(negedge HCLK);
    wr(A_STATUS, 32'h80);
    rd(A_STATUS, 32'h80, "set_wins");
    @(negedge HCLK);
    check("irq_fall", 32'(IRQ), 32'd1);
    wr(A_RISE_EN, 32'h00);
    wr(A_FALL_EN, 32'h00);
    rd(A_STATUS, 32'h80, "en_clear_keeps_status");
    check("irq_pending", 32'(IRQ), 32'd1);

    // All channels pending, then asynchronous reset mid-cycle
    wr(A_RISE_EN, 32'hFF);
    wr(A_FALL_EN, 32'hFF);
    BUTTON = 8'hFA;
    repeat (10) @(negedge HCLK);
    rd(A_DATA,   32'hFA, "data_all");
    rd(A_STATUS, 32'hFF, "status_all");
    check("irq_all", 32'(IRQ), 32'd1);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = A_STATUS;
    exp_q.push_back(32'hFF);
    tag_q.push_back("status_pre_reset");
    @(posedge HCLK);
    #2;
    check(tag_q.pop_front(), HRDATA, exp_q.pop_front());
    HRESETn = 1'b0;
    BUTTON  = '0;
    #1;
    check("hrdata_async_reset", HRDATA, 32'h0);
    check("irq_async_reset", 32'(IRQ), 32'd0);
    @(negedge HCLK);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    rd(A_DATA,    32'h0, "post_reset_data");
    rd(A_RAW,     32'h0, "post_reset_raw");
    rd(A_RISE_EN, 32'h0, "post_reset_rise_en");
    rd(A_FALL_EN, 32'h0, "post_reset_fall_en");
    rd(A_STATUS,  32'h0, "post_reset_status");
    check("post_reset_irq", 32'(IRQ), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
